// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } uart_rx_state_t;

  // Clocks per serial bit, truncated to an integer.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk from input change to o_sync.
// Backpressure: none; the output follows the input continuously.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; both stages reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its midpoint and emits received bytes.
// Latency: o_RX_DV rises ~9.5 bit periods + 2-3 clk after the start-bit falling edge.
// Backpressure: none; the consumer must accept the one-cycle o_RX_DV strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FPGA_clk_freq = 50000000,
  parameter int baudrate      = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int CLKS_PER_BIT = clks_per_bit(FPGA_clk_freq, baudrate);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_ratio
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic             w_rx_s;
  logic             w_half_done;
  logic             w_bit_done;
  uart_rx_state_t   r_state;
  uart_rx_state_t   w_next_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_dv;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_RX_Serial),
    .o_sync  (w_rx_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: a low line in IDLE is always taken as a start; only start and stop are validated.
  always_comb begin
    w_next_state = r_state;
    w_half_done  = (r_clk_cnt == HALF_M1);
    w_bit_done   = (r_clk_cnt == FULL_M1);
    case (r_state)
      IDLE:    if (!w_rx_s) w_next_state = START;
      START:   if (w_half_done) w_next_state = w_rx_s ? IDLE : DATA;
      DATA:    if (w_bit_done && (r_bit_idx == 3'd7)) w_next_state = STOP;
      STOP:    if (w_bit_done) w_next_state = CLEANUP;
      CLEANUP: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Counters, shift register and output byte/strobe; a bad stop bit leaves o_RX_Byte untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_byte    <= 8'h00;
      r_dv      <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= 3'd0;
        end
        START: begin
          if (w_half_done) r_clk_cnt <= '0;
          else             r_clk_cnt <= r_clk_cnt + 1'b1;
        end
        DATA: begin
          if (w_bit_done) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              r_byte <= r_shift;
              r_dv   <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_clk_cnt <= '0;
          r_bit_idx <= 3'd0;
        end
      endcase
    end
  end

  assign o_RX_DV   = r_dv;
  assign o_RX_Byte = r_byte;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_NS = 8680;

  logic       clk;
  logic       rst;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;

  int tests_run;
  int tests_failed;

  // DV monitor state
  int         dv_count;
  int         dv_double;
  logic       dv_prev;
  logic [7:0] rx_q[$];

  uart_rx #(
    .FPGA_clk_freq (50000000),
    .baudrate      (115200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_RX_Serial (i_RX_Serial),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Record every strobe and flag any strobe longer than one cycle.
  initial begin
    dv_count  = 0;
    dv_double = 0;
    dv_prev   = 1'b0;
  end
  always @(negedge clk) begin
    if (o_RX_DV === 1'b1) begin
      dv_count++;
      rx_q.push_back(o_RX_Byte);
      if (dv_prev) dv_double++;
    end
    dv_prev = (o_RX_DV === 1'b1);
  end

  // Drive one frame; caller aligns to negedge so transitions stay mid-cycle.
  task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_val);
    i_RX_Serial = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      i_RX_Serial = b[i];
      #(bit_ns);
    end
    i_RX_Serial = stop_val;
    #(bit_ns);
    i_RX_Serial = 1'b1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    dv_count  = 0;
    dv_double = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_RX_Serial = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (o_RX_DV !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_dv: got %b expected 0", o_RX_DV);
    end
    tests_run++;
    if (o_RX_Byte !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_byte: got %h expected 00", o_RX_Byte);
    end
    @(negedge clk);
    rst = 1'b0;
    #(BIT_NS * 2);
  endtask

  task automatic test_single();
    clear_mon();
    @(negedge clk);
    send_byte(8'h37, BIT_NS, 1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    if (o_RX_Byte !== 8'h37) begin
      tests_failed++;
      $display("FAIL single_byte: got %h expected 37", o_RX_Byte);
    end
    #(BIT_NS * 2);
    tests_run++;
    if (dv_count !== 1) begin
      tests_failed++;
      $display("FAIL single_dv_count: got %0d expected 1", dv_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00;
    exp[1] = 8'hFF;
    exp[2] = 8'hA5;
    clear_mon();
    @(negedge clk);
    for (int k = 0; k < 3; k++) send_byte(exp[k], BIT_NS, 1'b1);
    #(BIT_NS * 2);
    tests_run++;
    if (rx_q.size() !== 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d expected 3", rx_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (rx_q[k] !== exp[k]) begin
          tests_failed++;
          $display("FAIL b2b_byte%0d: got %h expected %h", k, rx_q[k], exp[k]);
        end
      end
    end
    tests_run++;
    if (dv_double !== 0) begin
      tests_failed++;
      $display("FAIL b2b_dv_width: got %0d multi-cycle strobes expected 0", dv_double);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    @(negedge clk);
    i_RX_Serial = 1'b0;
    #2000;
    i_RX_Serial = 1'b1;
    #(BIT_NS * 12);
    tests_run++;
    if (dv_count !== 0) begin
      tests_failed++;
      $display("FAIL glitch_no_dv: got %0d strobes expected 0", dv_count);
    end
    @(negedge clk);
    send_byte(8'h5A, BIT_NS, 1'b1);
    #(BIT_NS * 2);
    tests_run++;
    if (rx_q.size() !== 1 || o_RX_Byte !== 8'h5A) begin
      tests_failed++;
      $display("FAIL glitch_next_byte: got %0d strobes byte %h expected 1 byte 5a", rx_q.size(), o_RX_Byte);
    end
  endtask

  task automatic test_framing_error();
    clear_mon();
    @(negedge clk);
    send_byte(8'hC3, BIT_NS, 1'b0);
    #(BIT_NS * 3);
    tests_run++;
    if (dv_count !== 0) begin
      tests_failed++;
      $display("FAIL frame_err_no_dv: got %0d strobes expected 0", dv_count);
    end
    tests_run++;
    if (o_RX_Byte !== 8'h5A) begin
      tests_failed++;
      $display("FAIL frame_err_hold: got %h expected 5a", o_RX_Byte);
    end
    @(negedge clk);
    send_byte(8'h3C, BIT_NS, 1'b1);
    #(BIT_NS * 2);
    tests_run++;
    if (rx_q.size() !== 1 || o_RX_Byte !== 8'h3C) begin
      tests_failed++;
      $display("FAIL frame_err_recover: got %0d strobes byte %h expected 1 byte 3c", rx_q.size(), o_RX_Byte);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    @(negedge clk);
    fork
      send_byte(8'h96, BIT_NS, 1'b1);
      begin
        // start bit + data bits 0..3, then half of bit 4
        #(BIT_NS * 5 + BIT_NS / 2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (o_RX_DV !== 1'b0 || o_RX_Byte !== 8'h00) begin
          tests_failed++;
          $display("FAIL midrst_outputs: got dv %b byte %h expected 0 00", o_RX_DV, o_RX_Byte);
        end
      end
    join
    #(BIT_NS);
    @(negedge clk);
    rst = 1'b0;
    #(BIT_NS * 3);
    tests_run++;
    if (dv_count !== 0) begin
      tests_failed++;
      $display("FAIL midrst_no_dv: got %0d strobes expected 0", dv_count);
    end
    @(negedge clk);
    send_byte(8'hE1, BIT_NS, 1'b1);
    #(BIT_NS * 2);
    tests_run++;
    if (rx_q.size() !== 1 || o_RX_Byte !== 8'hE1) begin
      tests_failed++;
      $display("FAIL midrst_recover: got %0d strobes byte %h expected 1 byte e1", rx_q.size(), o_RX_Byte);
    end
  endtask

  task automatic test_baud_skew();
    int periods [2];
    periods[0] = 8420;
    periods[1] = 8940;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      @(negedge clk);
      send_byte(8'h69, periods[k], 1'b1);
      #(BIT_NS * 2);
      tests_run++;
      if (rx_q.size() !== 1) begin
        tests_failed++;
        $display("FAIL skew_%0dns_count: got %0d expected 1", periods[k], rx_q.size());
      end else begin
        tests_run++;
        if (rx_q[0] !== 8'h69) begin
          tests_failed++;
          $display("FAIL skew_%0dns_byte: got %h expected 69", periods[k], rx_q[0]);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    i_RX_Serial  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_baud_skew();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
